if2_fetch_queue: RTL and testbench

//  Parametrised fetch stage 2: receives a fetch line (FETCH_W instructions) plus its PC from IF1 with the

---
 rtl/if2_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_if2_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if2_fetch_queue.sv
// if2_fetch_queue: fetch stage 2 line queue.
// Holds up to DEPTH fetch lines from IF1 and hands them to ID one
// instruction per cycle over a valid/ready handshake. A line fetched for an
// unaligned PC starts at its slot, so earlier instructions are skipped.
// Flush and branch redirect both empty the queue and drop the input beat.
module if2_fetch_queue #(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      br_e,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [FETCH_W*INST_W-1:0] in_line,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [INST_W-1:0]         out_inst
);

    localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 0;
    // Slot registers keep at least one bit; with one slot per line they stay 0.
    localparam int HS_W   = (SLOT_W > 0) ? SLOT_W : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = FETCH_W * INST_W;

    localparam logic [HS_W-1:0]  LAST_SLOT = HS_W'(FETCH_W - 1);
    localparam logic [PC_W-1:0]  LOW_MASK  = PC_W'(FETCH_W * 4 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [LINE_W-1:0] line_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic [HS_W-1:0]  head_slot;
    logic [HS_W-1:0]  in_slot;
    logic [HS_W-1:0]  next_slot;

    logic clear;
    logic push;
    logic pop;
    logic deq;

    logic [PC_W-1:0]   head_pc;
    logic [LINE_W-1:0] head_line;

    // Slot index of the first wanted instruction inside a line.
    function automatic logic [HS_W-1:0] slot_of(input logic [PC_W-1:0] pc);
        return HS_W'(pc >> 2) & LAST_SLOT;
    endfunction

    assign clear     = flush | br_e;
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~clear;
    assign pop       = out_valid & out_ready & ~clear;
    assign deq       = pop & (head_slot == LAST_SLOT);
    assign rd_next   = rd_ptr + PTR_W'(1);
    assign in_slot   = slot_of(in_pc);

    // Start slot of whichever line becomes head after the current one leaves.
    always_comb begin
        next_slot = '0;
        if (count > ONE_CNT) begin
            next_slot = slot_of(pc_mem[rd_next]);
        end else if (push) begin
            next_slot = in_slot;
        end else begin
            next_slot = '0;
        end
    end

    // Head instruction selection; outputs read as zero while the queue is empty.
    always_comb begin
        head_pc   = pc_mem[rd_ptr];
        head_line = line_mem[rd_ptr];
        out_pc    = '0;
        out_inst  = '0;
        if (out_valid) begin
            out_pc   = (head_pc & ~LOW_MASK) | (PC_W'(head_slot) << 2);
            out_inst = head_line[int'(head_slot) * INST_W +: INST_W];
        end else begin
            out_pc   = '0;
            out_inst = '0;
        end
    end

    // Pointers, occupancy and head-slot tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_slot <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_slot <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_next;
            end
            count <= count + CNT_W'(push) - CNT_W'(deq);
            if (deq) begin
                head_slot <= next_slot;
            end else if (pop) begin
                head_slot <= head_slot + HS_W'(1);
            end else if (push && (count == '0)) begin
                head_slot <= in_slot;
            end
        end
    end

    // Line storage, written on every accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                line_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            line_mem[wr_ptr] <= in_line;
        end
    end

endmodule

// File: tb/tb_if2_fetch_queue.sv
// Self-checking bench for if2_fetch_queue (FETCH_W=2, DEPTH=4).
// Stimulus updates an instruction-level reference queue on every accepted
// line; an independent monitor compares the DUT outputs every cycle.
module tb_if2_fetch_queue;

    localparam int FW     = 2;
    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 br_e;
    logic                 in_valid;
    logic                 in_ready;
    logic [PC_W-1:0]      in_pc;
    logic [FW*INST_W-1:0] in_line;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_W-1:0]      out_pc;
    logic [INST_W-1:0]    out_inst;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t expq[$];      // instructions still owed to ID, in order
    int   line_rem[$];  // undelivered instruction count of each held line
    logic ready_snap = 1'b0;
    int   tests = 0;
    int   fails = 0;

    if2_fetch_queue #(.FETCH_W(FW), .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .br_e(br_e),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_line(in_line),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand an accepted line into the instructions ID must receive.
    task automatic model_push(input logic [31:0] pc, input logic [FW*INST_W-1:0] ln);
        int slot;
        logic [31:0] base;
        exp_t e;
        slot = int'((pc >> 2) % FW);
        base = pc & ~(32'(FW * 4) - 32'd1);
        for (int k = slot; k < FW; k++) begin
            e.pc   = base + 32'(4 * k);
            e.inst = ln[k*INST_W +: INST_W];
            expq.push_back(e);
        end
        line_rem.push_back(FW - slot);
    endtask

    // Monitor: compare outputs mid-cycle and retire instructions ID takes.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(line_rem.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(expq.size() != 0));
            ready_snap = (line_rem.size() != DEPTH);
            if (expq.size() == 0) begin
                chk("idle_pc", 64'(out_pc), 64'd0);
                chk("idle_inst", 64'(out_inst), 64'd0);
            end else begin
                chk("out_pc", 64'(out_pc), 64'(expq[0].pc));
                chk("out_inst", 64'(out_inst), 64'(expq[0].inst));
                if (out_ready && !flush && !br_e) begin
                    void'(expq.pop_front());
                    line_rem[0] = line_rem[0] - 1;
                    if (line_rem[0] == 0) void'(line_rem.pop_front());
                end
            end
        end
    end

    // One clock cycle of stimulus; acc reports whether the beat was taken.
    task automatic step(input logic v, input logic [31:0] pc, input logic [FW*INST_W-1:0] ln,
                        input logic ordy, input logic fl, input logic br, output logic acc);
        @(posedge clk);
        #1;
        in_valid = v; in_pc = pc; in_line = ln; out_ready = ordy; flush = fl; br_e = br;
        @(negedge clk);
        #1;
        acc = 1'b0;
        if (fl || br) begin
            expq.delete();
            line_rem.delete();
        end else if (v && ready_snap) begin
            model_push(pc, ln);
            acc = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        logic acc;
        int n;
        n = 0;
        while (expq.size() != 0 && n < 60) begin
            step(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0, acc);
            n++;
        end
        chk(name, 64'(expq.size()), 64'd0);
        step(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    task automatic fill(input int n, input int base);
        logic acc;
        int i, g;
        i = 0; g = 0;
        while (i < n && g < 50) begin
            step(1'b1, 32'(base + 8 * i), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
            if (acc) i++;
            g++;
        end
        chk("fill_done", 64'(i), 64'(n));
    endtask

    initial begin
        logic acc;
        logic hv;
        logic [31:0] hpc;
        logic [FW*INST_W-1:0] hln;
        int i, g;

        rst = 1'b1; flush = 1'b0; br_e = 1'b0; in_valid = 1'b0; in_pc = '0; in_line = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // aligned line, both slots delivered
        step(1'b1, 32'h1000, {32'h0000_0BBB, 32'h0000_0AAA}, 1'b1, 1'b0, 1'b0, acc);
        drain("drain_aligned");

        // unaligned start: only slot 1 delivered
        step(1'b1, 32'h1004, {32'h0000_0DDD, 32'h0000_0CCC}, 1'b1, 1'b0, 1'b0, acc);
        drain("drain_unaligned");

        // fill to full with ID stalled, then drain through pointer wrap
        i = 0; g = 0;
        while (i < 10 && g < 200) begin
            step(1'b1, 32'h2000 + 32'(8 * i) + ((i % 3 == 1) ? 32'd4 : 32'd0),
                 {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)},
                 (g >= 8) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, acc);
            if (acc) i++;
            g++;
        end
        chk("push10_done", 64'(i), 64'd10);
        drain("drain_wrap");

        // branch redirect with a live beat, then flush
        fill(3, 32'h3000);
        step(1'b1, 32'h3100, {32'hDEAD_0001, 32'hDEAD_0000}, 1'b1, 1'b0, 1'b1, acc);
        drain("drain_br");
        fill(3, 32'h4000);
        step(1'b1, 32'h4100, {32'hDEAD_0003, 32'hDEAD_0002}, 1'b1, 1'b1, 1'b0, acc);
        drain("drain_flush");

        // asynchronous reset in the middle of traffic
        fill(3, 32'h5000);
        @(posedge clk);
        #3 rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
        chk("mid_rst_out_inst", 64'(out_inst), 64'd0);
        expq.delete();
        line_rem.delete();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // randomized valid/ready stress with occasional redirects
        hv = 1'b0; hpc = '0; hln = '0;
        for (int c = 0; c < 3000; c++) begin
            logic fl, br;
            if (!hv) begin
                hv  = 1'($urandom_range(0, 2) != 0);
                hpc = $urandom;
                hln = {$urandom, $urandom};
            end
            fl = 1'($urandom_range(0, 59) == 0);
            br = 1'($urandom_range(0, 59) == 0);
            step(hv, hpc, hln, 1'($urandom_range(0, 3) != 0), fl, br, acc);
            if (acc || fl || br) hv = 1'b0;
        end
        drain("drain_stress");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
